pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Sequences the 32-bit program counter register: decides each cycle whether the PC advances and to which address.
//  Issues the instruction-fetch request for the current PC and waits for the fetch handshake.
//  Holds the PC for hazard stalls and selects among sequential, branch, jump and exception targets.
//  Captures redirects that arrive while a fetch is outstanding. Drives PCNext/PCWrite of the PC register directly.
// PARAMETERS
//  EXC_VECTOR   32'h0000_0180   address loaded into the PC on an exception
//  PC_STEP      4               sequential increment (bytes)
// PORTS
//  Clk           in   1   system clock, rising edge
//  Reset         in   1   synchronous, active-high reset
//  PCCurrent     in   32  current PC register value (PCResult)
//  IMemReady     in   1   instruction memory has returned the word for PCCurrent (single-cycle strobe)
//  Stall         in   1   hazard unit requests PC hold (load-use, multicycle op busy)
//  BranchTaken   in   1   resolved taken branch, 1-cycle pulse
//  BranchTarget  in   32  branch target, valid with BranchTaken
//  Jump          in   1   jump/jr, 1-cycle pulse
//  JumpTarget    in   32  jump target, valid with Jump
//  Exception     in   1   exception request, 1-cycle pulse
//  PCNext        out  32  next PC value to the PC register
//  PCWrite       out  1   PC load enable
//  IFetchReq     out  1   fetch request for PCCurrent
//  Flush         out  1   1-cycle pulse: squash IF/ID contents
//  EPC           out  32  PC of the faulting instruction, registered
// BEHAVIOUR
//  Reset (sync, active-high): state=BOOT, pending redirect cleared, EPC=0; PCWrite=0, IFetchReq=0, Flush=0, PCNext=0.
//  Reset mid-fetch: outstanding fetch abandoned; IMemReady ignored in BOOT.
//  States:
//   BOOT  -> FETCH after 1 cycle, all outputs 0.
//   FETCH -> IFetchReq=1.
//            IMemReady=1 & Stall=0: PCWrite=1, stay in FETCH.
//            IMemReady=1 & Stall=1: go to HOLD, PCWrite=0.
//            IMemReady=0: PCWrite=0, wait (no timeout).
//   HOLD  -> IFetchReq=0, PCWrite=0 while Stall=1.
//            Stall=0: PCWrite=1, go to FETCH.
//  Redirect capture: BranchTaken/Jump seen in a cycle where PCWrite=0 are stored in a pending register (valid+target+kind).
//   A later higher-priority redirect replaces the pending entry; a later redirect of equal priority overwrites it.
//   Pending is cleared on the cycle PCWrite=1.
//  PCNext select priority (combinational, used when PCWrite=1):
//   Exception > Jump (live or pending) > Branch (live or pending) > PCCurrent+PC_STEP.
//  Exception handling (any state except BOOT):
//   Takes effect the same cycle, overrides Stall and IMemReady.
//   PCWrite=1, PCNext=EXC_VECTOR, Flush=1 for that cycle.
//   EPC<=PCCurrent at the clock edge; pending cleared; next state FETCH.
//   Exception in BOOT is ignored.
//  Flush also pulses (1 cycle) whenever a jump/branch redirect is written.
//  Arithmetic: PCCurrent+PC_STEP is 32-bit and wraps modulo 2^32 (0xFFFFFFFC -> 0x00000000).
//   Targets have bits[1:0] forced to 0.
//  Latency: the PC register loads PCNext on the same rising edge that samples PCWrite=1.
//   Redirect-to-fetch at the new address is 1 cycle.
// TESTING
//  1 Reset 2 cycles, IMemReady=1 tied, PC model connected from 0
//    -> BOOT 1 cycle; then PCWrite every cycle, PCNext = 4, 8, C, ...
//  2 IMemReady low 3 cycles in FETCH
//    -> IFetchReq=1 held, PCWrite=0 for 3 cycles; single PCWrite with PCCurrent+4 on ready.
//  3 BranchTaken, target 0x100, while IMemReady=0, ready 2 cycles later
//    -> PCNext=0x100, PCWrite=1, Flush=1 on the ready cycle; pending then empty.
//  4 Jump 0x200 and BranchTaken 0x100 in the same cycle with ready
//    -> PCNext=0x200. Exception added in that same cycle -> PCNext=0x180, Flush=1, EPC=PCCurrent.
//  5 Stall=1 on a ready cycle for 4 cycles
//    -> HOLD, PCWrite=0, IFetchReq=0. Exception on cycle 2 -> immediate PCNext=0x180, state FETCH.
//  6 PCCurrent=0xFFFFFFFC, ready, no redirects -> PCNext=0x00000000.
//    Reset asserted while a fetch is outstanding -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Program-counter sequencing bus: PC register, instruction memory, hazard and redirect signals.
// master: the sequencer. slave: the datapath and hazard side that feeds it.
interface pc_sequencer_if;
  logic [31:0] PCCurrent;
  logic        IMemReady;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Exception;
  logic [31:0] PCNext;
  logic        PCWrite;
  logic        IFetchReq;
  logic        Flush;
  logic [31:0] EPC;

  modport master (
    input  PCCurrent, IMemReady, Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Exception,
    output PCNext, PCWrite, IFetchReq, Flush, EPC
  );

  modport slave (
    output PCCurrent, IMemReady, Stall, BranchTaken, BranchTarget, Jump, JumpTarget, Exception,
    input  PCNext, PCWrite, IFetchReq, Flush, EPC
  );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer: issues fetches, holds on stalls, selects the next PC and remembers redirects
// that arrive while the PC cannot be written.
module pc_sequencer #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int unsigned PC_STEP    = 4
) (
  input logic            Clk,
  input logic            Reset,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_jump_q, pend_jump_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic [31:0] epc_q, epc_d;

  logic        exc_live;
  logic        pc_write;
  logic        fetch_req;
  logic        redirect;
  logic [31:0] pc_sel;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;
  logic [31:0] seq_pc;

  // Word-align redirect targets; sequential step wraps modulo 2^32
  assign branch_tgt = bus.BranchTarget & ~32'h3;
  assign jump_tgt   = bus.JumpTarget & ~32'h3;
  assign seq_pc     = bus.PCCurrent + 32'(PC_STEP);
  assign exc_live   = bus.Exception && !Reset && (state_q != StBoot);

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= StBoot;
      pend_valid_q  <= 1'b0;
      pend_jump_q   <= 1'b0;
      pend_target_q <= 32'h0;
      epc_q         <= 32'h0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_jump_q   <= pend_jump_d;
      pend_target_q <= pend_target_d;
      epc_q         <= epc_d;
    end
  end

  // Next-state: exceptions force FETCH; a ready fetch under stall parks in HOLD
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StFetch;
      StFetch: begin
        if (exc_live) begin
          state_d = StFetch;
        end else if (bus.IMemReady && bus.Stall) begin
          state_d = StHold;
        end
      end
      StHold:  begin
        if (exc_live || !bus.Stall) begin
          state_d = StFetch;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs: PC load enable and fetch request per state; reset silences everything
  always_comb begin
    pc_write  = 1'b0;
    fetch_req = 1'b0;
    if (!Reset) begin
      unique case (state_q)
        StBoot:  ;
        StFetch: begin
          fetch_req = 1'b1;
          pc_write  = exc_live || (bus.IMemReady && !bus.Stall);
        end
        StHold:  pc_write = exc_live || !bus.Stall;
        default: ;
      endcase
    end
  end

  // Next-PC select: exception > jump (live, then pending) > branch (live, then pending) > step
  always_comb begin
    redirect = 1'b1;
    pc_sel   = seq_pc;
    if (exc_live) begin
      pc_sel = EXC_VECTOR;
    end else if (bus.Jump) begin
      pc_sel = jump_tgt;
    end else if (pend_valid_q && pend_jump_q) begin
      pc_sel = pend_target_q;
    end else if (bus.BranchTaken) begin
      pc_sel = branch_tgt;
    end else if (pend_valid_q) begin
      pc_sel = pend_target_q;
    end else begin
      redirect = 1'b0;
    end
  end

  // Pending redirect: held until the PC is written; a branch never displaces a pending jump
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_jump_d   = pend_jump_q;
    pend_target_d = pend_target_q;
    if (pc_write) begin
      pend_valid_d = 1'b0;
    end else if (bus.Jump || (bus.BranchTaken && !(pend_valid_q && pend_jump_q))) begin
      pend_valid_d  = 1'b1;
      pend_jump_d   = bus.Jump;
      pend_target_d = bus.Jump ? jump_tgt : branch_tgt;
    end
  end

  // EPC captures the faulting PC on the exception edge
  always_comb begin
    epc_d = exc_live ? bus.PCCurrent : epc_q;
  end

  assign bus.PCWrite   = pc_write;
  assign bus.PCNext    = pc_write ? pc_sel : 32'h0;
  assign bus.IFetchReq = fetch_req;
  assign bus.Flush     = pc_write && (exc_live || redirect);
  assign bus.EPC       = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a PC register model closes the loop; expected outputs are queued
// per driven cycle, observed outputs are captured at the falling edge and compared per task.
module tb_pc_sequencer;
  logic Clk = 1'b0;
  logic Reset;
  logic [31:0] pc;
  logic pc_ld;
  logic [31:0] pc_ldv;
  logic [34:0] exp_q[$];
  logic [34:0] got_q[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  pc_sequencer_if bus();

  pc_sequencer #(.EXC_VECTOR(32'h0000_0180), .PC_STEP(4)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  // PC register model
  assign bus.PCCurrent = pc;
  always @(posedge Clk) begin
    if (Reset) pc <= 32'h0;
    else if (pc_ld) pc <= pc_ldv;
    else if (bus.PCWrite) pc <= bus.PCNext;
  end

  // Expected {PCWrite, IFetchReq, Flush, PCNext}; PCNext only matters when PCWrite=1
  function automatic logic [34:0] ex(input logic wr, req, fl, input logic [31:0] p);
    return {wr, req, fl, wr ? p : 32'h0};
  endfunction

  task automatic cycle(input logic rst, ld, input logic [31:0] ldv, input logic rdy, stl, br,
                       input logic [31:0] bt, input logic j, input logic [31:0] jt,
                       input logic exc, input logic [34:0] e);
    @(posedge Clk);
    #1;
    Reset = rst; pc_ld = ld; pc_ldv = ldv;
    bus.IMemReady = rdy; bus.Stall = stl;
    bus.BranchTaken = br; bus.BranchTarget = bt;
    bus.Jump = j; bus.JumpTarget = jt; bus.Exception = exc;
    exp_q.push_back(e);
    @(negedge Clk);
    got_q.push_back({bus.PCWrite, bus.IFetchReq, bus.Flush,
                     bus.PCWrite ? bus.PCNext : 32'h0});
  endtask

  task automatic test_reset;
    logic [34:0] e, g;
    int idx = 0;
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 32'h0));
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 32'h0));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 32'h0));
    for (int i = 1; i <= 4; i++) cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 32'(4 * i)));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: got wr=%b req=%b fl=%b pc=%h, want wr=%b req=%b fl=%b pc=%h",
                 idx, g[34], g[33], g[32], g[31:0], e[34], e[33], e[32], e[31:0]);
      end
      idx++;
    end
  endtask

  task automatic test_not_ready;
    logic [34:0] e, g;
    int idx = 0;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 32'h14));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL not_ready[%0d]: got wr=%b req=%b fl=%b pc=%h, want wr=%b req=%b fl=%b pc=%h",
                 idx, g[34], g[33], g[32], g[31:0], e[34], e[33], e[32], e[31:0]);
      end
      idx++;
    end
  endtask

  task automatic test_branch_pending;
    logic [34:0] e, g;
    int idx = 0;
    cycle(0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 1, 32'h100));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 32'h104));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL branch_pend[%0d]: got wr=%b req=%b fl=%b pc=%h, want wr=%b req=%b fl=%b pc=%h",
                 idx, g[34], g[33], g[32], g[31:0], e[34], e[33], e[32], e[31:0]);
      end
      idx++;
    end
  endtask

  task automatic test_priority;
    logic [34:0] e, g;
    int idx = 0;
    cycle(0, 0, 0, 1, 0, 1, 32'h100, 1, 32'h200, 0, ex(1, 1, 1, 32'h200));
    cycle(0, 0, 0, 1, 0, 1, 32'h100, 1, 32'h200, 1, ex(1, 1, 1, 32'h180));
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(0, 1, 0, 32'h0));
    n_tests++;
    if (bus.EPC !== 32'h200) begin
      n_fail++;
      $display("FAIL epc_priority: got %h, want %h", bus.EPC, 32'h200);
    end
    // Low target bits are dropped
    cycle(0, 0, 0, 1, 0, 0, 0, 1, 32'h203, 0, ex(1, 1, 1, 32'h200));
    // Pending jump survives a later branch
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 32'h300, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 0, 0, 1, 32'h400, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 1, 32'h300));
    // Later branch overwrites a pending branch
    cycle(0, 0, 0, 0, 0, 1, 32'h500, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 0, 0, 1, 32'h600, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 1, 32'h600));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL priority[%0d]: got wr=%b req=%b fl=%b pc=%h, want wr=%b req=%b fl=%b pc=%h",
                 idx, g[34], g[33], g[32], g[31:0], e[34], e[33], e[32], e[31:0]);
      end
      idx++;
    end
  endtask

  task automatic test_stall;
    logic [34:0] e, g;
    int idx = 0;
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, ex(0, 0, 0, 32'h0));
    cycle(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, ex(1, 0, 1, 32'h180));
    cycle(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, ex(0, 1, 0, 32'h0));
    n_tests++;
    if (bus.EPC !== 32'h600) begin
      n_fail++;
      $display("FAIL epc_stall: got %h, want %h", bus.EPC, 32'h600);
    end
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ex(1, 0, 0, 32'h184));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 32'h188));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL stall[%0d]: got wr=%b req=%b fl=%b pc=%h, want wr=%b req=%b fl=%b pc=%h",
                 idx, g[34], g[33], g[32], g[31:0], e[34], e[33], e[32], e[31:0]);
      end
      idx++;
    end
  endtask

  task automatic test_wrap_and_reset;
    logic [34:0] e, g;
    int idx = 0;
    cycle(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 32'h0));
    // Outstanding fetch with a pending branch, then reset
    cycle(0, 0, 0, 0, 0, 1, 32'h700, 0, 0, 0, ex(0, 1, 0, 32'h0));
    cycle(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 32'h0));
    // BOOT ignores ready and exception
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, ex(0, 0, 0, 32'h0));
    n_tests++;
    if (bus.EPC !== 32'h0) begin
      n_fail++;
      $display("FAIL epc_reset: got %h, want %h", bus.EPC, 32'h0);
    end
    cycle(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, ex(1, 1, 0, 32'h4));
    n_tests++;
    if (bus.EPC !== 32'h0) begin
      n_fail++;
      $display("FAIL epc_boot_exc: got %h, want %h", bus.EPC, 32'h0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL wrap_reset[%0d]: got wr=%b req=%b fl=%b pc=%h, want wr=%b req=%b fl=%b pc=%h",
                 idx, g[34], g[33], g[32], g[31:0], e[34], e[33], e[32], e[31:0]);
      end
      idx++;
    end
  endtask

  initial begin
    Reset = 1'b1; pc_ld = 1'b0; pc_ldv = 32'h0;
    bus.IMemReady = 1'b0; bus.Stall = 1'b0;
    bus.BranchTaken = 1'b0; bus.BranchTarget = 32'h0;
    bus.Jump = 1'b0; bus.JumpTarget = 32'h0; bus.Exception = 1'b0;
    test_reset();
    test_not_ready();
    test_branch_pending();
    test_priority();
    test_stall();
    test_wrap_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
